// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the bit-serial adder
package serial_adder_pkg;
  localparam int DEFAULT_WIDTH = 8;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: combinational one-bit full adder reused every cycle by the serial datapath
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: LSB-first bit-serial add/subtract with start/busy/done handshake and overflow flag
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_next;
  logic [CNT_W-1:0] cnt;
  logic             carry, c_msb_in, s_bit, c_bit;

  fa_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .s    (s_bit),
    .cout (c_bit)
  );

  assign s_next = {s_bit, s_sr[WIDTH-1:1]};
  assign busy   = state == ST_RUN;
  assign done   = state == ST_DONE;

  // Capture operands in IDLE, ripple one bit per cycle in RUN, publish the result on entry to DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      s_sr     <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          a_sr  <= a;
          b_sr  <= sub ? ~b : b;
          carry <= sub ? 1'b1 : cin;
          cnt   <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          s_sr  <= s_next;
          carry <= c_bit;
          if (cnt == CNT_W'(WIDTH - 2)) c_msb_in <= c_bit;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            sum   <= s_next;
            cout  <= c_bit;
            ovf   <= c_msb_in ^ c_bit;
            state <= ST_DONE;
          end else cnt <= cnt + 1'b1;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for 8-bit and 3-bit serial adders plus the full-adder cell
module tb_serial_adder;
  typedef struct packed {
    logic        ov;
    logic        co;
    logic [31:0] s;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  logic       start3 = 1'b0, sub3 = 1'b0, cin3 = 1'b0;
  logic [2:0] a3 = '0, b3 = '0;
  logic       busy3, done3, cout3, ovf3;
  logic [2:0] sum3;
  logic       fa_a, fa_b, fa_c, fa_s, fa_co;

  int   n_chk = 0, n_fail = 0;
  exp_t q8[$], q3[$];
  exp_t e8, e3;
  logic [9:0] held8 = '0;
  logic [4:0] held3 = '0;
  logic prev8 = 1'b0, prev3 = 1'b0;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(3)) u3 (
    .clk(clk), .rst(rst), .start(start3), .sub(sub3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .ovf(ovf3)
  );

  fa_cell u_fa (.a(fa_a), .b(fa_b), .cin(fa_c), .s(fa_s), .cout(fa_co));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  // Reference: plain integer add of a, effective b and carry-in; overflow from operand/result signs
  function automatic exp_t ref_model(input int w, input logic [31:0] x, input logic [31:0] y,
                                     input logic c, input logic s);
    logic [63:0] m, yy, t;
    exp_t r;
    m    = (64'd1 << w) - 64'd1;
    yy   = s ? (~{32'd0, y} & m) : {32'd0, y};
    t    = {32'd0, x} + yy + (s ? 64'd1 : {63'd0, c});
    r.s  = 32'(t & m);
    r.co = t[w];
    r.ov = (x[w-1] == yy[w-1]) && (t[w-1] != x[w-1]);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) held8 = '0;
    else if (done8) begin
      chk("q8_pending", q8.size() != 0, 1);
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        chk("sum8", sum8, e8.s[7:0]);
        chk("cout8", cout8, e8.co);
        chk("ovf8", ovf8, e8.ov);
      end
      chk("done8_pulse", prev8, 0);
      held8 = {ovf8, cout8, sum8};
    end else chk("hold8", {ovf8, cout8, sum8}, held8);
    prev8 = done8;
  end

  always @(negedge clk) begin
    if (rst) held3 = '0;
    else if (done3) begin
      chk("q3_pending", q3.size() != 0, 1);
      if (q3.size() != 0) begin
        e3 = q3.pop_front();
        chk("sum3", sum3, e3.s[2:0]);
        chk("cout3", cout3, e3.co);
        chk("ovf3", ovf3, e3.ov);
      end
      chk("done3_pulse", prev3, 0);
      held3 = {ovf3, cout3, sum3};
    end else chk("hold3", {ovf3, cout3, sum3}, held3);
    prev3 = done3;
  end

  task automatic issue8(input logic [7:0] x, input logic [7:0] y, input logic c, input logic s);
    a8 = x; b8 = y; cin8 = c; sub8 = s; start8 = 1'b1;
    q8.push_back(ref_model(8, 32'(x), 32'(y), c, s));
    @(posedge clk);
    #1 start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
  endtask

  task automatic wait8(output int n, output int k);
    n = 0; k = 0;
    while (!done8 && k < 40) begin
      @(negedge clk);
      k++;
      if (busy8) n++;
    end
    chk("done8_seen", done8, 1);
  endtask

  task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic c, input logic s);
    int n, k;
    issue8(x, y, c, s);
    wait8(n, k);
    chk("busy8_cycles", n, 8);
    chk("done8_cycle", k, 9);
    @(posedge clk);
    #1;
  endtask

  task automatic run3(input logic [2:0] x, input logic [2:0] y, input logic c, input logic s);
    int n, k;
    a3 = x; b3 = y; cin3 = c; sub3 = s; start3 = 1'b1;
    q3.push_back(ref_model(3, 32'(x), 32'(y), c, s));
    @(posedge clk);
    #1 start3 = 1'b0;
    a3 = 3'($urandom); b3 = 3'($urandom); cin3 = 1'($urandom); sub3 = 1'($urandom);
    n = 0; k = 0;
    while (!done3 && k < 20) begin
      @(negedge clk);
      k++;
      if (busy3) n++;
    end
    chk("done3_seen", done3, 1);
    chk("busy3_cycles", n, 3);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, k;
    for (int i = 0; i < 8; i++) begin
      {fa_a, fa_b, fa_c} = 3'(i);
      #1 chk("fa_cell", {fa_co, fa_s}, $countones(3'(i)));
    end
    @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);
    chk("rst_ovf", ovf8, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run8(8'h0F, 8'h01, 1'b0, 1'b0);
    run8(8'hFF, 8'h01, 1'b1, 1'b0);
    run8(8'h7F, 8'h01, 1'b0, 1'b0);
    run8(8'h05, 8'h07, 1'b1, 1'b1);
    run8(8'h80, 8'h01, 1'b0, 1'b1);

    issue8(8'h10, 8'h10, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    @(posedge clk);
    #1 start8 = 1'b0;
    wait8(n, k);
    chk("ign_busy_cycles", n, 5);
    @(posedge clk);
    #1;

    issue8(8'h33, 8'h44, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    q8.delete();
    #1;
    chk("abort_sum", sum8, 0);
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_cout", cout8, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    run8(8'h01, 8'h02, 1'b0, 1'b0);

    start8 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
      if (i % 10 == 0) q8.push_back(ref_model(8, 32'(a8), 32'(b8), cin8, sub8));
      @(posedge clk);
      @(negedge clk);
      chk("stream_done", done8, i % 10 == 8);
    end
    start8 = 1'b0;
    @(posedge clk);
    #1;

    repeat (40) run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));

    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        for (int c = 0; c < 2; c++)
          run3(3'(x), 3'(y), 1'(c), 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("q8_drained", q8.size(), 0);
    chk("q3_drained", q3.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised, bit-serial add/subtract unit. One full-adder cell is reused over WIDTH clock cycles, LSB first.
- Generalises the single-bit full adder to N-bit operands, with a start/busy/done handshake, a subtract mode and a signed-overflow flag.
- Used where area matters more than latency; results are consumed on the done pulse.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = a+b+cin, 1 = a-b (a + ~b + 1; cin ignored); captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- cin  input  1  carry-in for add mode; captured with start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse; result valid.
- sum  output  WIDTH  registered result.
- cout  output  1  carry out of MSB; in sub mode 1 = no borrow.
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; shift registers, counter and carry cleared. Reset mid-RUN aborts the operation and the result registers do not update.
- States: IDLE, RUN, DONE, encoded as 2-bit constants.
- IDLE: if start=1 at an edge:
  - load A_sr=a and B_sr = sub ? ~b : b.
  - carry = sub ? 1 : cin; cnt=0; go to RUN. Otherwise stay in IDLE.
- RUN: each edge runs fa_cell(A_sr[0], B_sr[0], carry):
  - the sum bit shifts into S_sr at MSB; A_sr and B_sr shift right; carry updates.
  - when cnt==WIDTH-2, the carry out of that edge is stored in c_msb_in (carry into the MSB).
  - when cnt==WIDTH-1: sum<=final S_sr, cout<=final carry, ovf<=c_msb_in^final carry; go to DONE.
  - otherwise cnt<=cnt+1.
- DONE: done=1 for exactly this cycle; next edge goes to IDLE unconditionally.
- Latency: start sampled at edge 0; RUN covers edges 1..WIDTH; done is high between edge WIDTH and edge WIDTH+1. busy is high for exactly WIDTH cycles.
- Throughput: start held high continuously gives one result per WIDTH+2 cycles. start is ignored in RUN and DONE, with no queuing.
- sum/cout/ovf change only on the RUN->DONE edge or reset. They hold their values through IDLE and through the next RUN.
- Inputs a, b, sub and cin may change freely after capture with no effect.
- Arithmetic is modulo 2^WIDTH; there is no saturation.

Decomposition:
- Shared package/header: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; default width constant.
- Sub-module fa_cell: combinational 1-bit full adder (a, b, cin -> s, cout). Unit-tested separately over all 8 input combinations.

Test Plan:
- WIDTH=8, a=8'h0F, b=8'h01, cin=0, sub=0, start pulse -> busy high 8 cycles; done at cycle 9; sum=8'h10, cout=0, ovf=0.
- a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1, ovf=0. Then a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, cout=0, ovf=1.
- sub=1, a=8'h05, b=8'h07, cin=1 -> sum=8'hFE, cout=0 (borrow), ovf=0 (cin ignored). Then sub=1, a=8'h80, b=8'h01 -> sum=8'h7F, cout=1, ovf=1.
- Start a=8'h10, b=8'h10; at RUN cycle 3 pulse start with a=8'hAA -> ignored, sum=8'h20. Next run: assert rst at RUN cycle 4 -> outputs 0 immediately, state IDLE; a following start a=8'h01, b=8'h02 -> sum=8'h03.
- start held high for 30 cycles -> done pulses exactly every 10 cycles; sum stable between pulses.
- WIDTH=3 instance, exhaustive over all a, b, cin with sub=0 (128 cases) -> {cout,sum}==a+b+cin; ovf matches signed reference model; done is a single-cycle pulse every case.
